// File: rtl/ccff_programmer.sv
// rtl/ccff_programmer.sv - configuration chain loader and non-destructive readback engine
module ccff_programmer #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WORD_W);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LD_FETCH = 3'd1;
  localparam logic [2:0] LD_SHIFT = 3'd2;
  localparam logic [2:0] RB_SHIFT = 3'd3;
  localparam logic [2:0] RB_PUSH  = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [WC_W-1:0]   wcnt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rbuf;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WC_W-1:0]   wcnt_nxt;

  assign cnt_nxt  = cnt + CNT_W'(1);
  assign wcnt_nxt = wcnt + WC_W'(1);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      sreg  <= '0;
      rbuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cnt   <= '0;
            wcnt  <= '0;
            rbuf  <= '0;
            state <= cmd_op ? RB_SHIFT : LD_FETCH;
          end
        end
        LD_FETCH: begin
          if (wr_valid) begin
            sreg  <= wr_data;
            wcnt  <= '0;
            state <= LD_SHIFT;
          end
        end
        LD_SHIFT: begin
          // Chain end wins over word end, so a partial last word drops its upper bits.
          sreg <= sreg >> 1;
          cnt  <= cnt_nxt;
          wcnt <= wcnt_nxt;
          if (cnt_nxt == CNT_LAST)
            state <= FINISH;
          else if (wcnt_nxt == WC_LAST)
            state <= LD_FETCH;
        end
        RB_SHIFT: begin
          rbuf <= rbuf | (WORD_W'(ccff_tail) << wcnt);
          cnt  <= cnt_nxt;
          wcnt <= wcnt_nxt;
          if (cnt_nxt == CNT_LAST || wcnt_nxt == WC_LAST)
            state <= RB_PUSH;
        end
        RB_PUSH: begin
          if (rd_ready) begin
            if (cnt == CNT_LAST) begin
              state <= FINISH;
            end else begin
              state <= RB_SHIFT;
              rbuf  <= '0;
              wcnt  <= '0;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tail is fed straight back to head during readback so the chain rotates intact.
  always_comb begin
    ccff_head = 1'b0;
    case (state)
      LD_SHIFT: ccff_head = sreg[0];
      RB_SHIFT: ccff_head = ccff_tail;
      default:  ccff_head = 1'b0;
    endcase
  end

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign wr_ready      = (state == LD_FETCH);
  assign rd_valid      = (state == RB_PUSH);
  assign rd_data       = rbuf;
  assign ccff_shift_en = (state == LD_SHIFT) || (state == RB_SHIFT);
  assign done          = (state == FINISH);

endmodule

// File: tb/tb_ccff_programmer.sv
// tb/tb_ccff_programmer.sv - directed bench for ccff_programmer with a 12-bit chain model
module tb_ccff_programmer;

  logic       prog_clk = 1'b0;
  logic       pReset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       ccff_head;
  logic       ccff_tail;
  logic       ccff_shift_en;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [11:0] chain = '0;
  int shifts = 0;
  int wr_hs = 0;
  int done_cnt = 0;

  ccff_programmer #(.CHAIN_LEN(12), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .pReset(pReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
    .busy(busy), .done(done)
  );

  always #5 prog_clk = ~prog_clk;

  // chain[11] is the tail; newest bit enters at chain[0]
  assign ccff_tail = chain[11];

  always @(posedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin
      chain  <= {chain[10:0], ccff_head};
      shifts <= shifts + 1;
    end
    if (wr_valid === 1'b1 && wr_ready === 1'b1) wr_hs <= wr_hs + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send_cmd(input logic op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
  endtask

  task automatic put_word(input logic [7:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end else begin
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL finish_state: cmd_ready=%b busy=%b, required 0/1", cmd_ready, busy);
      end
      tick;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL back_to_idle: cmd_ready=%b busy=%b done=%b, required 1/0/0",
                 cmd_ready, busy, done);
      end
    end
  endtask

  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                         input bit poke, output int run0);
    int n = 0;
    run0 = 0;
    send_cmd(1'b0);
    put_word(w0);
    if (poke) begin
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
    end
    while (wr_ready !== 1'b1 && n < 50) begin
      if (poke) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_cmd_ready: cmd_ready=%b during load shift, required 0", cmd_ready);
        end
      end
      if (ccff_shift_en === 1'b1) run0++;
      tick;
      n++;
    end
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL fetch_timeout: wr_ready=%b after %0d cycles, required 1", wr_ready, n);
    end
    for (int g = 0; g < gap; g++) begin
      checks++;
      if (ccff_shift_en !== 1'b0 || wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL starve_gap: shift_en=%b wr_ready=%b, required 0/1", ccff_shift_en, wr_ready);
      end
      tick;
    end
    put_word(w1);
    wait_done;
  endtask

  task automatic do_readback(input int stall, output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] words [2];
    logic [7:0] snap;
    for (int i = 0; i < 2; i++) words[i] = 8'h00;
    send_cmd(1'b1);
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      while (rd_valid !== 1'b1 && n < 50) begin
        tick;
        n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL rd_timeout: rd_valid=%b after %0d cycles, required 1", rd_valid, n);
      end
      if (i == 0 && stall > 0) begin
        snap = rd_data;
        for (int s = 0; s < stall; s++) begin
          checks++;
          if (rd_valid !== 1'b1 || rd_data !== snap || ccff_shift_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: rd_valid=%b rd_data=%h shift_en=%b, required 1/%h/0",
                     rd_valid, rd_data, ccff_shift_en, snap);
          end
          tick;
        end
      end
      words[i] = rd_data;
      rd_ready = 1'b1;
      tick;
      rd_ready = 1'b0;
    end
    wait_done;
    r0 = words[0];
    r1 = words[1];
  endtask

  task automatic test_reset;
    int s0;
    pReset = 1'b1;
    tick;
    s0 = shifts;
    tick;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready=%b busy=%b done=%b, required 1/0/0", cmd_ready, busy, done);
    end
    checks++;
    if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: wr_ready=%b rd_valid=%b rd_data=%h, required 0/0/00",
               wr_ready, rd_valid, rd_data);
    end
    checks++;
    if (ccff_head !== 1'b0 || ccff_shift_en !== 1'b0 || shifts != s0) begin
      errors++;
      $display("FAIL reset_chain: head=%b shift_en=%b shifts=%0d, required 0/0/0",
               ccff_head, ccff_shift_en, shifts - s0);
    end
    pReset = 1'b0;
    tick;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || ccff_shift_en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: cmd_ready=%b busy=%b shift_en=%b, required 1/0/0",
               cmd_ready, busy, ccff_shift_en);
    end
  endtask

  task automatic test_load;
    int s0 = shifts;
    int h0 = wr_hs;
    int d0 = done_cnt;
    int run0;
    do_load(8'hA5, 8'h0F, 0, 1'b0, run0);
    checks++;
    if (run0 != 8) begin
      errors++;
      $display("FAIL load_first_run: got %0d shifts, required 8", run0);
    end
    checks++;
    if (shifts - s0 != 12 || wr_hs - h0 != 2 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL load_counts: shifts=%0d handshakes=%0d dones=%0d, required 12/2/1",
               shifts - s0, wr_hs - h0, done_cnt - d0);
    end
    checks++;
    if (chain !== 12'hA5F) begin
      errors++;
      $display("FAIL load_chain: got %h, required a5f", chain);
    end
  endtask

  task automatic test_readback(input int stall);
    int s0 = shifts;
    logic [7:0] r0;
    logic [7:0] r1;
    do_readback(stall, r0, r1);
    checks++;
    if (r0 !== 8'hA5 || r1 !== 8'h0F) begin
      errors++;
      $display("FAIL rb_words stall=%0d: got %h %h, required a5 0f", stall, r0, r1);
    end
    checks++;
    if (chain !== 12'hA5F || shifts - s0 != 12) begin
      errors++;
      $display("FAIL rb_chain stall=%0d: chain=%h shifts=%0d, required a5f/12",
               stall, chain, shifts - s0);
    end
  endtask

  task automatic test_reset_mid_load;
    int s0;
    int run0;
    send_cmd(1'b0);
    put_word(8'hFF);
    for (int i = 0; i < 5; i++) tick;
    pReset = 1'b1;
    tick;
    checks++;
    if (ccff_shift_en !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: shift_en=%b busy=%b cmd_ready=%b, required 0/0/1",
               ccff_shift_en, busy, cmd_ready);
    end
    pReset = 1'b0;
    tick;
    s0 = shifts;
    do_load(8'h3C, 8'h0A, 0, 1'b0, run0);
    checks++;
    if (chain !== 12'h3C5 || shifts - s0 != 12) begin
      errors++;
      $display("FAIL reload_chain: chain=%h shifts=%0d, required 3c5/12", chain, shifts - s0);
    end
  endtask

  task automatic test_starvation;
    int s0 = shifts;
    int run0;
    do_load(8'hA5, 8'h0F, 4, 1'b0, run0);
    checks++;
    if (chain !== 12'hA5F || shifts - s0 != 12 || run0 != 8) begin
      errors++;
      $display("FAIL starve_chain: chain=%h shifts=%0d run0=%0d, required a5f/12/8",
               chain, shifts - s0, run0);
    end
  endtask

  task automatic test_busy_cmd;
    int s0 = shifts;
    int run0;
    do_load(8'h3C, 8'h0A, 0, 1'b1, run0);
    checks++;
    if (shifts - s0 != 12 || chain !== 12'h3C5) begin
      errors++;
      $display("FAIL busy_load: shifts=%0d chain=%h, required 12/3c5", shifts - s0, chain);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || ccff_shift_en !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_queue: busy=%b shift_en=%b, required 0/0", busy, ccff_shift_en);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_readback(0);
    test_readback(5);
    test_reset_mid_load;
    test_starvation;
    test_busy_cmd;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_programmer.md
Name: ccff_programmer

Overview:
- Bitstream loader and reader for the configuration chain (ccff_head -> mux mem cells -> ccff_tail) that threads through every routing and logic tile.
- Accepts configuration words from the host side, serializes them onto ccff_head, and emits a shift enable that drives the chain's prog_clk gate.
- Also performs a non-destructive readback: it recirculates ccff_tail into ccff_head and returns the captured bits as words.
- Sits at the fabric top, between the host I/O interface and the head and tail of the chain.

Parameters:
- CHAIN_LEN, 256, total configuration bits in the chain (>=1)
- WORD_W, 8, host word width (>=1)
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived; do not override)

Ports:
- prog_clk  input  1  programming clock
- pReset  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE
- cmd_op  input  1  0 = load, 1 = readback
- wr_data  input  WORD_W  load word, LSB shifted first
- wr_valid  input  1  load word valid
- wr_ready  output  1  load word accepted when wr_valid & wr_ready
- rd_data  output  WORD_W  readback word, first captured bit in LSB
- rd_valid  output  1  readback word valid
- rd_ready  input  1  readback consumer ready
- ccff_head  output  1  serial bit into the chain
- ccff_tail  input  1  serial bit out of the chain
- ccff_shift_en  output  1  chain advances at the prog_clk edge ending any cycle where this is 1
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at the end of a load or readback

Behaviour:
- Clock and reset: one clock, prog_clk. Reset is synchronous and active-high on pReset.
- Reset values: state IDLE; cmd_ready=1; all other outputs 0 (wr_ready, rd_valid, rd_data, ccff_head, ccff_shift_en, busy, done); bit counter 0.
- Reset mid-operation aborts immediately. ccff_shift_en is 0 from the next cycle; chain contents are left partial and undefined.
- States: IDLE, LD_FETCH, LD_SHIFT, RB_SHIFT, RB_PUSH, FINISH.
- IDLE:
  - cmd_valid & cmd_ready: cmd_op=0 -> LD_FETCH, cmd_op=1 -> RB_SHIFT.
  - In both cases the bit counter is cleared to 0.
- LD_FETCH:
  - wr_ready=1, ccff_shift_en=0.
  - On handshake, latch wr_data into the shift register and go to LD_SHIFT.
  - Waits indefinitely while wr_valid=0.
- LD_SHIFT, each cycle:
  - ccff_shift_en=1; ccff_head=sreg[0]; sreg shifts right; counter+1.
  - Leave after WORD_W bits or when counter reaches CHAIN_LEN, whichever is first.
  - Counter==CHAIN_LEN -> FINISH; else -> LD_FETCH.
  - Partial final word (CHAIN_LEN mod WORD_W != 0): only the low bits are used; upper bits are ignored.
  - Bits leaving ccff_tail during a load are discarded.
  - Word throughput: one fetch cycle plus WORD_W shift cycles.
- RB_SHIFT, each cycle:
  - ccff_shift_en=1; ccff_head=ccff_tail (recirculate); capture ccff_tail into rd_data bit k, where k = bits taken so far in this word; counter+1.
  - After WORD_W bits, or when counter reaches CHAIN_LEN, go to RB_PUSH.
  - Unfilled upper bits of the final word read 0.
- RB_PUSH:
  - rd_valid=1, ccff_shift_en=0; rd_data stays stable until rd_ready.
  - On handshake: counter==CHAIN_LEN -> FINISH; else -> RB_SHIFT with the word buffer cleared.
  - Back-pressure stalls the chain without losing bits.
- Readback outcome: after exactly CHAIN_LEN shifts the chain holds its original contents. The readback word stream equals the most recent load word stream, including partial-word masking.
- FINISH: done=1 for one cycle, then IDLE.
- Commands are never queued. cmd_ready=0 whenever not in IDLE, so cmd_valid while busy is ignored.
- ccff_shift_en is never 1 outside LD_SHIFT and RB_SHIFT.
- CHAIN_LEN < WORD_W: a single partial word, handled by the same rules.

Test Plan:
- Setup: CHAIN_LEN=12, WORD_W=8; the bench models the chain as a 12-bit shift register clocked when ccff_shift_en=1.
- Reset: hold pReset 2 cycles -> all outputs 0 except cmd_ready=1; no shift_en pulses.
- Load 0xA5, 0x0F (op=0):
  - 12 shift_en cycles total, split 8+4, with wr_ready high for exactly 2 handshakes.
  - Model chain = bits 1,0,1,0,0,1,0,1,1,1,1,1 in shift order.
  - done pulses once; cmd_ready returns to 1 the next cycle.
- Readback after the above load (op=1):
  - rd_data returns 0xA5 then 0x0F (upper nibble 0).
  - Model chain is unchanged afterwards; exactly 12 shift_en cycles.
- Back-pressure: readback with rd_ready held low 5 cycles on the first word -> rd_valid and rd_data stable; shift_en=0 throughout the stall; final data still 0xA5, 0x0F.
- Write starvation: during load, wr_valid low 4 cycles between words -> no shift_en in the gap; the final chain image is identical to the first load test.
- Reset mid-load: assert pReset after 5 shift cycles -> IDLE next cycle, shift_en=0; a fresh load of 0x3C, 0x0A yields chain bits 0,0,1,1,1,1,0,0,0,1,0,1.
- Busy command: cmd_valid with op=1 during LD_SHIFT -> not accepted (cmd_ready=0); the load completes with exactly 12 shifts.
